// File: rtl/uart_dbg_bridge_pkg.sv
// Shared opcodes, reply/error codes, bus request struct and FSM states for the UART debug bridge.
package uart_dbg_bridge_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_READ    = 8'h02;

  localparam logic [7:0] RSP_WR_OK   = 8'h81;
  localparam logic [7:0] RSP_RD_OK   = 8'h82;
  localparam logic [7:0] RSP_ERR     = 8'hEE;

  localparam logic [7:0] ERR_BUS     = 8'h01;
  localparam logic [7:0] ERR_TIMEOUT = 8'h02;
  localparam logic [7:0] ERR_OPCODE  = 8'h03;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS_REQ,
    ST_BUS_WAIT,
    ST_SEND_RESP
  } bridge_state_e;

endpackage

// File: rtl/uart_dbg_byte_rx.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling, byte/frame-error strobes.
module uart_dbg_byte_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          rx_s;

  assign rx_s   = sync_q[1];
  assign byte_o = sh_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    sh_d         = sh_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sh_d  = {rx_s, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == FULL) begin
        cnt_d = '0;
        if (rx_s) begin
          byte_valid_o = 1'b1;
          state_d      = RX_IDLE;
        end else begin
          frame_err_o = 1'b1;
          state_d     = RX_BREAK;
        end
      end
      // a low stop bit must not be mistaken for the next start bit
      RX_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_dbg_bridge.sv
// UART command frames -> single 32-bit bus access -> UART response.
// Define UART_BRIDGE_TIMEOUT_EN to enable the bus watchdog (TIMEOUT_CYCLES).
module uart_dbg_bridge
  import uart_dbg_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 434,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        req_o,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  output logic        busy_o
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  bridge_state_e state_q, state_d;
  bus_req_t      bus_q;
  logic          req_q;
  logic [1:0]    byte_cnt_q;
  logic [39:0]   resp_q, resp_d;
  logic [2:0]    nresp_q, nresp_d;
  logic          resp_ld, tx_ld, tx_busy, timeout;
  logic [7:0]    rx_byte;
  logic          rx_vld, rx_ferr;
  logic          tx_q;
  logic [8:0]    tx_frm_q;
  logic [3:0]    tx_bits_q;
  logic [CW-1:0] tx_cnt_q;

  uart_dbg_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rx_i         (rx_i),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_vld),
    .frame_err_o  (rx_ferr)
  );

  assign tx_o    = tx_q;
  assign req_o   = req_q;
  assign we_o    = bus_q.we;
  assign be_o    = 4'hF;
  assign addr_o  = bus_q.addr;
  assign wdata_o = bus_q.wdata;
  assign busy_o  = (state_q != ST_IDLE);
  assign tx_busy = (tx_bits_q != 4'd0);

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          on_bus;

  assign on_bus  = (state_q == ST_BUS_REQ) || (state_q == ST_BUS_WAIT);
  assign timeout = on_bus && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       tmo_q <= '0;
    else if (on_bus) tmo_q <= tmo_q + 1'b1;
    else             tmo_q <= '0;
  end
`else
  // watchdog compiled out: the bridge waits on the bus indefinitely
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    resp_ld = 1'b0;
    resp_d  = '0;
    nresp_d = '0;
    tx_ld   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (rx_vld) begin
        if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
          state_d = ST_GET_ADDR;
        end else begin
          state_d = ST_SEND_RESP;
          resp_ld = 1'b1;
          resp_d  = {24'h0, ERR_OPCODE, RSP_ERR};
          nresp_d = 3'd2;
        end
      end
      ST_GET_ADDR: begin
        if (rx_ferr) state_d = ST_IDLE;
        else if (rx_vld && byte_cnt_q == 2'd3) state_d = bus_q.we ? ST_GET_DATA : ST_BUS_REQ;
      end
      ST_GET_DATA: begin
        if (rx_ferr) state_d = ST_IDLE;
        else if (rx_vld && byte_cnt_q == 2'd3) state_d = ST_BUS_REQ;
      end
      ST_BUS_REQ, ST_BUS_WAIT: begin
        if (state_q == ST_BUS_REQ && gnt_i) state_d = ST_BUS_WAIT;
        // response may arrive in the grant cycle itself
        if ((state_q == ST_BUS_WAIT || gnt_i) && rvalid_i) begin
          state_d = ST_SEND_RESP;
          resp_ld = 1'b1;
          if (err_i) begin
            resp_d  = {24'h0, ERR_BUS, RSP_ERR};
            nresp_d = 3'd2;
          end else if (bus_q.we) begin
            resp_d  = {32'h0, RSP_WR_OK};
            nresp_d = 3'd1;
          end else begin
            resp_d  = {rdata_i, RSP_RD_OK};
            nresp_d = 3'd5;
          end
        end else if (timeout) begin
          state_d = ST_SEND_RESP;
          resp_ld = 1'b1;
          resp_d  = {24'h0, ERR_TIMEOUT, RSP_ERR};
          nresp_d = 3'd2;
        end
      end
      ST_SEND_RESP: begin
        tx_ld = !tx_busy && (nresp_q != 3'd0);
        if (!tx_busy && nresp_q == 3'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      bus_q      <= '0;
      req_q      <= 1'b0;
      byte_cnt_q <= '0;
      resp_q     <= '0;
      nresp_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == ST_BUS_REQ);
      if (state_q == ST_IDLE && rx_vld) begin
        bus_q.we   <= (rx_byte == CMD_WRITE);
        byte_cnt_q <= '0;
      end
      // masking bits [1:0] on every shift only drops bits about to fall off
      if (state_q == ST_GET_ADDR && rx_vld) begin
        bus_q.addr <= {rx_byte, bus_q.addr[31:8]} & 32'hFFFF_FFFC;
        byte_cnt_q <= byte_cnt_q + 1'b1;
      end
      if (state_q == ST_GET_DATA && rx_vld) begin
        bus_q.wdata <= {rx_byte, bus_q.wdata[31:8]};
        byte_cnt_q  <= byte_cnt_q + 1'b1;
      end
      if (resp_ld) begin
        resp_q  <= resp_d;
        nresp_q <= nresp_d;
      end else if (tx_ld) begin
        resp_q  <= {8'h0, resp_q[39:8]};
        nresp_q <= nresp_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_q      <= 1'b1;
      tx_frm_q  <= '1;
      tx_bits_q <= '0;
      tx_cnt_q  <= '0;
    end else if (tx_ld) begin
      tx_q      <= 1'b0;
      tx_frm_q  <= {1'b1, resp_q[7:0]};
      tx_bits_q <= 4'd10;
      tx_cnt_q  <= '0;
    end else if (tx_busy) begin
      if (tx_cnt_q == FULL) begin
        tx_cnt_q  <= '0;
        tx_bits_q <= tx_bits_q - 4'd1;
        tx_q      <= tx_frm_q[0];
        tx_frm_q  <= {1'b1, tx_frm_q[8:1]};
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Directed bench for uart_dbg_bridge: serial driver, serial decoder and a hand-driven bus responder.
module tb_uart_dbg_bridge;
  localparam int CPB = 8;
  localparam int TMO = 1024;

  logic        clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic        gnt = 1'b0, rvalid = 1'b0, err = 1'b0;
  logic [31:0] rdata = '0;
  logic        tx, req, we, busy;
  logic [3:0]  be;
  logic [31:0] addr, wdata;

  int          n_chk = 0, n_pass = 0, cyc = 0, req_cnt = 0, req_rise = 0;
  logic        req_prev = 1'b0;
  logic [7:0]  txq[$];
  logic [7:0]  tx_b;
  bit          ok;

  uart_dbg_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .tx_o(tx), .req_o(req), .we_o(we), .be_o(be),
    .addr_o(addr), .wdata_o(wdata), .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(rdata),
    .err_i(err), .busy_o(busy));

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // cycle stamp and request-rise counter
  initial forever begin
    @(negedge clk);
    cyc++;
    if (req === 1'b1 && req_prev !== 1'b1) begin req_cnt++; req_rise = cyc; end
    req_prev = req;
  end

  // serial decoder on tx
  initial forever begin
    @(negedge clk);
    if (tx === 1'b0 && !rst) begin
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin repeat (CPB) @(negedge clk); tx_b[i] = tx; end
      repeat (CPB) @(negedge clk);
      txq.push_back(tx_b);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0; repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (CPB) @(negedge clk); end
    rx = stop; repeat (CPB) @(negedge clk);
    rx = 1'b1; repeat (2) @(negedge clk);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic wait_req(output bit got);
    int n;
    n = 0;
    while (req !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    got = (req === 1'b1);
  endtask

  task automatic wait_tx(input int cnt, output bit got);
    int n;
    n = 0;
    while ((txq.size() < cnt || busy !== 1'b0) && n < 3000) begin @(negedge clk); n++; end
    got = (txq.size() >= cnt) && (busy === 1'b0);
  endtask

  task automatic bus_resp(input logic [31:0] d, input logic e, input bit same);
    gnt = 1'b1;
    if (same) begin rvalid = 1'b1; rdata = d; err = e; end
    @(negedge clk); gnt = 1'b0; rvalid = 1'b0;
    if (!same) begin
      @(negedge clk); rvalid = 1'b1; rdata = d; err = e;
      @(negedge clk); rvalid = 1'b0;
    end
    err = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; repeat (3) @(negedge clk);
    n_chk++; if (tx !== 1'b1)     $display("FAIL reset_tx got %b exp 1", tx); else n_pass++;
    n_chk++; if (req !== 1'b0)    $display("FAIL reset_req got %b exp 0", req); else n_pass++;
    n_chk++; if (we !== 1'b0)     $display("FAIL reset_we got %b exp 0", we); else n_pass++;
    n_chk++; if (be !== 4'hF)     $display("FAIL reset_be got %h exp f", be); else n_pass++;
    n_chk++; if (addr !== 32'h0)  $display("FAIL reset_addr got %h exp 0", addr); else n_pass++;
    n_chk++; if (wdata !== 32'h0) $display("FAIL reset_wdata got %h exp 0", wdata); else n_pass++;
    n_chk++; if (busy !== 1'b0)   $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    rst = 1'b0; repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    int rc;
    rc = req_cnt; txq.delete();
    send_write(32'h0000_0010, 32'hDEAD_BEEF);
    wait_req(ok);
    n_chk++; if (!ok) $display("FAIL wr_req_seen got 0 exp 1"); else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++; if (req !== 1'b1)           $display("FAIL wr_req_held got %b exp 1", req); else n_pass++;
    n_chk++; if (we !== 1'b1)            $display("FAIL wr_we got %b exp 1", we); else n_pass++;
    n_chk++; if (addr !== 32'h10)        $display("FAIL wr_addr got %h exp 00000010", addr); else n_pass++;
    n_chk++; if (wdata !== 32'hDEADBEEF) $display("FAIL wr_wdata got %h exp deadbeef", wdata); else n_pass++;
    n_chk++; if (be !== 4'hF)            $display("FAIL wr_be got %h exp f", be); else n_pass++;
    gnt = 1'b1; @(negedge clk); gnt = 1'b0;
    n_chk++; if (req !== 1'b0) $display("FAIL wr_req_drop got %b exp 0", req); else n_pass++;
    repeat (2) @(negedge clk); rvalid = 1'b1; @(negedge clk); rvalid = 1'b0;
    wait_tx(1, ok);
    n_chk++; if (!ok) $display("FAIL wr_tx_done got %0d bytes exp 1", txq.size()); else n_pass++;
    n_chk++; if (txq.size() != 1 || txq[0] !== 8'h81)
      $display("FAIL wr_resp got %0d bytes first %h exp 1 byte 81", txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx);
    else n_pass++;
    n_chk++; if (req_cnt - rc != 1) $display("FAIL wr_req_count got %0d exp 1", req_cnt - rc); else n_pass++;
  endtask

  task automatic test_read;
    logic [39:0] e;
    e = 40'h00_0000_0382; txq.delete();
    rvalid = 1'b1; rdata = 32'hBAD0_BAD0; @(negedge clk); rvalid = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++; if (busy !== 1'b0 || txq.size() != 0) $display("FAIL rd_stray_rvalid got busy %b exp 0", busy); else n_pass++;
    send_read(32'h0000_0008);
    wait_req(ok);
    n_chk++; if (!ok) $display("FAIL rd_req_seen got 0 exp 1"); else n_pass++;
    n_chk++; if (we !== 1'b0)     $display("FAIL rd_we got %b exp 0", we); else n_pass++;
    n_chk++; if (addr !== 32'h08) $display("FAIL rd_addr got %h exp 00000008", addr); else n_pass++;
    bus_resp(32'h0000_0003, 1'b0, 1'b1);
    send_byte(8'h55);  // lands during SEND_RESP and must be discarded
    wait_tx(5, ok);
    repeat (300) @(negedge clk);
    n_chk++; if (txq.size() != 5) $display("FAIL rd_resp_len got %0d exp 5", txq.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (txq.size() <= i || txq[i] !== e[8*i +: 8])
        $display("FAIL rd_resp[%0d] got %h exp %h", i, (txq.size() > i) ? txq[i] : 8'hxx, e[8*i +: 8]);
      else n_pass++;
    end
  endtask

  task automatic test_bus_err;
    txq.delete();
    send_read(32'h0000_0004);
    wait_req(ok);
    n_chk++; if (!ok) $display("FAIL be_req_seen got 0 exp 1"); else n_pass++;
    bus_resp(32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_tx(2, ok);
    n_chk++; if (txq.size() != 2 || txq[0] !== 8'hEE || txq[1] !== 8'h01)
      $display("FAIL be_resp got %0d bytes %h %h exp ee 01", txq.size(),
               (txq.size() > 0) ? txq[0] : 8'hxx, (txq.size() > 1) ? txq[1] : 8'hxx);
    else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL be_busy got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_bad_opcode;
    int rc;
    rc = req_cnt; txq.delete();
    send_byte(8'h55);
    wait_tx(2, ok);
    n_chk++; if (txq.size() != 2 || txq[0] !== 8'hEE || txq[1] !== 8'h03)
      $display("FAIL op_resp got %0d bytes %h %h exp ee 03", txq.size(),
               (txq.size() > 0) ? txq[0] : 8'hxx, (txq.size() > 1) ? txq[1] : 8'hxx);
    else n_pass++;
    txq.delete();
    send_byte(8'h02);
    n_chk++; if (busy !== 1'b1) $display("FAIL fe_busy_cmd got %b exp 1", busy); else n_pass++;
    send_byte(8'h08, 1'b0);
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL fe_busy_idle got %b exp 0", busy); else n_pass++;
    repeat (300) @(negedge clk);
    n_chk++; if (txq.size() != 0) $display("FAIL fe_no_tx got %0d bytes exp 0", txq.size()); else n_pass++;
    n_chk++; if (req_cnt != rc) $display("FAIL op_no_req got %0d exp 0", req_cnt - rc); else n_pass++;
  endtask

  task automatic test_timeout;
    int k;
    txq.delete();
    send_read(32'h0000_0040);
    wait_req(ok);
    n_chk++; if (!ok) $display("FAIL to_req_seen got 0 exp 1"); else n_pass++;
`ifdef UART_BRIDGE_TIMEOUT_EN
    k = 0;
    while (req === 1'b1 && k < 5000) begin @(negedge clk); k++; end
    k = cyc - req_rise;
    n_chk++; if (req !== 1'b0 || k < TMO - 1 || k > TMO + 1)
      $display("FAIL to_req_drop got req %b after %0d cycles exp 0 after %0d", req, k, TMO);
    else n_pass++;
    wait_tx(2, ok);
    n_chk++; if (txq.size() != 2 || txq[0] !== 8'hEE || txq[1] !== 8'h02)
      $display("FAIL to_resp got %0d bytes %h %h exp ee 02", txq.size(),
               (txq.size() > 0) ? txq[0] : 8'hxx, (txq.size() > 1) ? txq[1] : 8'hxx);
    else n_pass++;
    rvalid = 1'b1; @(negedge clk); rvalid = 1'b0;
    repeat (200) @(negedge clk);
    n_chk++; if (txq.size() != 2 || busy !== 1'b0)
      $display("FAIL to_late_rvalid got %0d bytes busy %b exp 2 bytes busy 0", txq.size(), busy);
    else n_pass++;
`else
    repeat (5000) @(negedge clk);
    n_chk++; if (req !== 1'b1) $display("FAIL to_req_held got %b exp 1", req); else n_pass++;
    bus_resp(32'h1234_5678, 1'b0, 1'b0);
    wait_tx(5, ok);
    k = (txq.size() == 5) ? {txq[4], txq[3], txq[2], txq[1]} : 0;
    n_chk++; if (txq.size() != 5 || txq[0] !== 8'h82 || k != 32'h1234_5678)
      $display("FAIL to_late_resp got %0d bytes data %h exp 82 + 12345678", txq.size(), k);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid;
    txq.delete();
    send_read(32'h0000_000C);
    wait_req(ok);
    n_chk++; if (!ok) $display("FAIL rm_req_seen got 0 exp 1"); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (req !== 1'b0)  $display("FAIL rm_req got %b exp 0", req); else n_pass++;
    n_chk++; if (tx !== 1'b1)   $display("FAIL rm_tx got %b exp 1", tx); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rm_busy got %b exp 0", busy); else n_pass++;
    @(negedge clk); rst = 1'b0; repeat (2) @(negedge clk);
    send_write(32'h0000_0020, 32'h1122_3344);
    wait_req(ok);
    n_chk++; if (!ok || addr !== 32'h20 || wdata !== 32'h11223344)
      $display("FAIL rm_next_req got addr %h wdata %h exp 00000020 11223344", addr, wdata);
    else n_pass++;
    bus_resp(32'h0, 1'b0, 1'b0);
    wait_tx(1, ok);
    n_chk++; if (txq.size() != 1 || txq[0] !== 8'h81)
      $display("FAIL rm_next_resp got %0d bytes first %h exp 81", txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bus_err();
    test_bad_opcode();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
